// File: rtl/id_stage_if.sv
// Fetch/writeback/decode bundle around the ID stage.
//   master : upstream side. It drives fetch, flush and writeback, and observes the ID/EX outputs.
//   slave  : id_stage side. It consumes fetch, flush and writeback, and drives the ID/EX outputs.
// Signals:
//   PC_IF/IDATA_IF  fetch PC and word. PC leads the word by one cycle.
//   FLUSH           squash the instruction entering ID this cycle.
//   WB_EN/WB_RD/WB_DATA  register-file write port from the last stage.
//   *_ID            registered ID/EX boundary.
interface id_stage_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    logic [XLEN-1:0]   PC_IF;
    logic [XLEN-1:0]   IDATA_IF;
    logic              FLUSH;
    logic              WB_EN;
    logic [REG_AW-1:0] WB_RD;
    logic [XLEN-1:0]   WB_DATA;

    logic [XLEN-1:0]   PC_ID;
    logic [XLEN-1:0]   IDATA_ID;
    logic              VALID_ID;
    logic              ILLEGAL_ID;
    logic [6:0]        OPCODE_ID;
    logic [2:0]        FUNCT3_ID;
    logic              FUNCT7B5_ID;
    logic [REG_AW-1:0] RD_ID;
    logic [REG_AW-1:0] RS1_ID;
    logic [REG_AW-1:0] RS2_ID;
    logic [XLEN-1:0]   RS1_DATA_ID;
    logic [XLEN-1:0]   RS2_DATA_ID;
    logic [XLEN-1:0]   IMM_ID;

    modport master (
        output PC_IF, IDATA_IF, FLUSH, WB_EN, WB_RD, WB_DATA,
        input  PC_ID, IDATA_ID, VALID_ID, ILLEGAL_ID, OPCODE_ID, FUNCT3_ID,
               FUNCT7B5_ID, RD_ID, RS1_ID, RS2_ID, RS1_DATA_ID, RS2_DATA_ID, IMM_ID
    );

    modport slave (
        input  PC_IF, IDATA_IF, FLUSH, WB_EN, WB_RD, WB_DATA,
        output PC_ID, IDATA_ID, VALID_ID, ILLEGAL_ID, OPCODE_ID, FUNCT3_ID,
               FUNCT7B5_ID, RD_ID, RS1_ID, RS2_ID, RS1_DATA_ID, RS2_DATA_ID, IMM_ID
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage.
// - Pairs each fetched word with its PC.
// - Reads operands from the owned 32x32 register file. Writeback data is passed through in the same cycle.
// - Builds the sign-extended immediate and flags illegal encodings.
// - Registers everything into the ID/EX boundary.
// Ports:
//   CLK   clock; all state updates on posedge
//   RSTN  asynchronous active-low reset
//   bus   id_stage_if.slave. Inputs are fetch, FLUSH and writeback. Outputs are the registered *_ID fields.
module id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic       CLK,
    input  logic       RSTN,
    id_stage_if.slave  bus
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned NUM_REG = 32;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Alignment state. The word arriving now belongs to the PC seen last cycle.
    logic [XLEN-1:0] pc_q;
    logic            align_valid;

    logic [XLEN-1:0] rf [NUM_REG];

    logic [XLEN-1:0]   pc_id_q;
    logic [XLEN-1:0]   idata_id_q;
    logic              valid_id_q;
    logic              illegal_id_q;
    logic [6:0]        opcode_id_q;
    logic [2:0]        funct3_id_q;
    logic              funct7b5_id_q;
    logic [REG_AW-1:0] rd_id_q;
    logic [REG_AW-1:0] rs1_id_q;
    logic [REG_AW-1:0] rs2_id_q;
    logic [XLEN-1:0]   rs1_data_id_q;
    logic [XLEN-1:0]   rs2_data_id_q;
    logic [XLEN-1:0]   imm_id_q;

    logic [XLEN-1:0]   inst_c;
    logic [6:0]        opcode_c;
    logic [REG_AW-1:0] rs1_c;
    logic [REG_AW-1:0] rs2_c;
    logic [XLEN-1:0]   imm_c;
    logic              illegal_c;
    logic              wb_write_c;
    logic [XLEN-1:0]   rs1_data_c;
    logic [XLEN-1:0]   rs2_data_c;
    logic              bubble_c;

    assign inst_c     = bus.IDATA_IF;
    assign opcode_c   = inst_c[6:0];
    assign rs1_c      = inst_c[19:15];
    assign rs2_c      = inst_c[24:20];
    assign wb_write_c = bus.WB_EN && (bus.WB_RD != REG_AW'(0));
    assign bubble_c   = bus.FLUSH || !align_valid;

    // Immediate generation and legality check, keyed on the opcode.
    always_comb begin
        imm_c     = '0;
        illegal_c = 1'b0;
        unique case (opcode_c)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:
                imm_c = {{20{inst_c[31]}}, inst_c[31:20]};
            OP_STORE:
                imm_c = {{20{inst_c[31]}}, inst_c[31:25], inst_c[11:7]};
            OP_BRANCH:
                imm_c = {{19{inst_c[31]}}, inst_c[31], inst_c[7],
                         inst_c[30:25], inst_c[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_c = {inst_c[31:12], 12'b0};
            OP_JAL:
                imm_c = {{11{inst_c[31]}}, inst_c[31], inst_c[19:12],
                         inst_c[20], inst_c[30:21], 1'b0};
            OP_REG:
                imm_c = '0;
            default:
                illegal_c = 1'b1;
        endcase
        // Every listed opcode ends in 2'b11. This check still covers the compressed space.
        if (inst_c[1:0] != 2'b11) begin
            illegal_c = 1'b1;
        end
    end

    // Operand read.
    // x0 is hard zero. A same-cycle writeback to the read index wins over the array.
    always_comb begin
        rs1_data_c = rf[rs1_c];
        rs2_data_c = rf[rs2_c];
        if (rs1_c == REG_AW'(0)) begin
            rs1_data_c = '0;
        end else if (wb_write_c && (bus.WB_RD == rs1_c)) begin
            rs1_data_c = bus.WB_DATA;
        end
        if (rs2_c == REG_AW'(0)) begin
            rs2_data_c = '0;
        end else if (wb_write_c && (bus.WB_RD == rs2_c)) begin
            rs2_data_c = bus.WB_DATA;
        end
    end

    // Fetch alignment.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_q        <= RESET_PC;
            align_valid <= 1'b0;
        end else begin
            pc_q        <= bus.PC_IF;
            align_valid <= 1'b1;
        end
    end

    // Register file. Writes ignore FLUSH and VALID. x0 is never written.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < int'(NUM_REG); i++) begin
                rf[i] <= '0;
            end
        end else if (wb_write_c) begin
            rf[bus.WB_RD] <= bus.WB_DATA;
        end
    end

    // ID/EX boundary.
    // A bubble keeps the aligned PC so downstream still sees the redirect slot.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_id_q       <= RESET_PC;
            idata_id_q    <= NOP_INSTR;
            valid_id_q    <= 1'b0;
            illegal_id_q  <= 1'b0;
            opcode_id_q   <= '0;
            funct3_id_q   <= '0;
            funct7b5_id_q <= 1'b0;
            rd_id_q       <= '0;
            rs1_id_q      <= '0;
            rs2_id_q      <= '0;
            rs1_data_id_q <= '0;
            rs2_data_id_q <= '0;
            imm_id_q      <= '0;
        end else if (bubble_c) begin
            pc_id_q       <= pc_q;
            idata_id_q    <= NOP_INSTR;
            valid_id_q    <= 1'b0;
            illegal_id_q  <= 1'b0;
            opcode_id_q   <= '0;
            funct3_id_q   <= '0;
            funct7b5_id_q <= 1'b0;
            rd_id_q       <= '0;
            rs1_id_q      <= '0;
            rs2_id_q      <= '0;
            rs1_data_id_q <= '0;
            rs2_data_id_q <= '0;
            imm_id_q      <= '0;
        end else begin
            pc_id_q       <= pc_q;
            idata_id_q    <= inst_c;
            valid_id_q    <= 1'b1;
            illegal_id_q  <= illegal_c;
            opcode_id_q   <= opcode_c;
            funct3_id_q   <= inst_c[14:12];
            funct7b5_id_q <= inst_c[30];
            rd_id_q       <= inst_c[11:7];
            rs1_id_q      <= rs1_c;
            rs2_id_q      <= rs2_c;
            rs1_data_id_q <= rs1_data_c;
            rs2_data_id_q <= rs2_data_c;
            imm_id_q      <= imm_c;
        end
    end

    assign bus.PC_ID       = pc_id_q;
    assign bus.IDATA_ID    = idata_id_q;
    assign bus.VALID_ID    = valid_id_q;
    assign bus.ILLEGAL_ID  = illegal_id_q;
    assign bus.OPCODE_ID   = opcode_id_q;
    assign bus.FUNCT3_ID   = funct3_id_q;
    assign bus.FUNCT7B5_ID = funct7b5_id_q;
    assign bus.RD_ID       = rd_id_q;
    assign bus.RS1_ID      = rs1_id_q;
    assign bus.RS2_ID      = rs2_id_q;
    assign bus.RS1_DATA_ID = rs1_data_id_q;
    assign bus.RS2_DATA_ID = rs2_data_id_q;
    assign bus.IMM_ID      = imm_id_q;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage.
// - A spec-level model predicts the ID/EX outputs at every edge.
// - Each falling edge compares the model against the DUT.
// - Directed points are additionally pinned to hand-computed literals.
module tb_id_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] idata;
        logic        valid;
        logic        illegal;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
    } out_t;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    logic [31:0] pc_ctr;

    id_stage_if bus();

    id_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state.
    logic [31:0] m_rf [32];
    logic [31:0] m_pc_prev;
    bit          m_aligned;
    out_t        exp_o;

    function automatic out_t reset_out(input logic [31:0] pc);
        out_t o;
        o       = '0;
        o.pc    = pc;
        o.idata = NOP_INSTR;
        return o;
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.WB_EN && bus.WB_RD == idx) return bus.WB_DATA;
        return m_rf[idx];
    endfunction

    // Instruction-format view of decode.
    function automatic out_t decode(input logic [31:0] pc, input logic [31:0] w);
        out_t o;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        o         = '0;
        o.pc      = pc;
        o.idata   = w;
        o.valid   = 1'b1;
        o.opcode  = w[6:0];
        o.funct3  = w[14:12];
        o.f7b5    = w[30];
        o.rd      = w[11:7];
        o.rs1     = w[19:15];
        o.rs2     = w[24:20];
        o.r1      = read_reg(w[19:15]);
        o.r2      = read_reg(w[24:20]);
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                i12   = w[31:20];
                o.imm = 32'($signed(i12));
            end
            7'h23: begin
                i12   = {w[31:25], w[11:7]};
                o.imm = 32'($signed(i12));
            end
            7'h63: begin
                b13   = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                o.imm = 32'($signed(b13));
            end
            7'h37, 7'h17: o.imm = w & 32'hFFFF_F000;
            7'h6F: begin
                j21   = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                o.imm = 32'($signed(j21));
            end
            7'h33: o.imm = 32'd0;
            default: o.illegal = 1'b1;
        endcase
        if (w[1:0] != 2'b11) o.illegal = 1'b1;
        return o;
    endfunction

    // Model: predict the boundary contents after each edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_pc_prev = RESET_PC;
            m_aligned = 1'b0;
            exp_o     = reset_out(RESET_PC);
        end else begin
            out_t nxt;
            if (bus.FLUSH || !m_aligned) nxt = reset_out(m_pc_prev);
            else                         nxt = decode(m_pc_prev, bus.IDATA_IF);
            if (bus.WB_EN && bus.WB_RD != 5'd0) m_rf[bus.WB_RD] = bus.WB_DATA;
            m_pc_prev = bus.PC_IF;
            m_aligned = 1'b1;
            exp_o     = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("pc_id",    bus.PC_ID,                 exp_o.pc);
        chk("idata_id", bus.IDATA_ID,              exp_o.idata);
        chk("valid_id", 32'(bus.VALID_ID),         32'(exp_o.valid));
        chk("illegal",  32'(bus.ILLEGAL_ID),       32'(exp_o.illegal));
        chk("opcode",   32'(bus.OPCODE_ID),        32'(exp_o.opcode));
        chk("funct3",   32'(bus.FUNCT3_ID),        32'(exp_o.funct3));
        chk("f7b5",     32'(bus.FUNCT7B5_ID),      32'(exp_o.f7b5));
        chk("rd",       32'(bus.RD_ID),            32'(exp_o.rd));
        chk("rs1",      32'(bus.RS1_ID),           32'(exp_o.rs1));
        chk("rs2",      32'(bus.RS2_ID),           32'(exp_o.rs2));
        chk("rs1_data", bus.RS1_DATA_ID,           exp_o.r1);
        chk("rs2_data", bus.RS2_DATA_ID,           exp_o.r2);
        chk("imm",      bus.IMM_ID,                exp_o.imm);
    end

    // One fetch cycle: PC_IF advances, IDATA_IF carries the word of the previous PC.
    task automatic cyc(input logic [31:0] idata, input logic flush,
                       input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data);
        bus.PC_IF    = pc_ctr;
        bus.IDATA_IF = idata;
        bus.FLUSH    = flush;
        bus.WB_EN    = wb_en;
        bus.WB_RD    = wb_rd;
        bus.WB_DATA  = wb_data;
        @(posedge clk);
        pc_ctr = pc_ctr + 32'd4;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        pc_ctr       = 32'd0;
        rstn         = 1'b0;
        bus.PC_IF    = 32'd0;
        bus.IDATA_IF = 32'd0;
        bus.FLUSH    = 1'b0;
        bus.WB_EN    = 1'b0;
        bus.WB_RD    = 5'd0;
        bus.WB_DATA  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.VALID_ID), 32'd0);
        chk("rst_idata", bus.IDATA_ID, 32'h0000_0013);
        chk("rst_imm",   bus.IMM_ID,   32'd0);
        rstn = 1'b1;

        // Edge 1: the fetch word is undefined, so the output is a bubble.
        cyc(32'hDEAD_0000, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("e1_valid", 32'(bus.VALID_ID), 32'd0);
        chk("e1_idata", bus.IDATA_ID, 32'h0000_0013);
        chk("e1_pc",    bus.PC_ID,    32'd0);

        // addi x1,x0,5 at PC 0.
        cyc(32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("e2_valid", 32'(bus.VALID_ID), 32'd1);
        chk("e2_pc",    bus.PC_ID,         32'd0);
        chk("e2_rd",    32'(bus.RD_ID),    32'd1);
        chk("e2_imm",   bus.IMM_ID,        32'd5);
        chk("e2_rs1d",  bus.RS1_DATA_ID,   32'd0);

        // add x2,x1,x1 while x1 is being written. Both operands should see the written value.
        cyc(32'h0010_8133, 1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF);
        chk("byp_rs1", bus.RS1_DATA_ID, 32'hDEAD_BEEF);
        chk("byp_rs2", bus.RS2_DATA_ID, 32'hDEAD_BEEF);
        chk("byp_pc",  bus.PC_ID,       32'd4);

        // addi x3,x1,0 reads the stored x1. A write to x0 is attempted at the same time.
        cyc(32'h0000_8193, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
        chk("rf_rs1", bus.RS1_DATA_ID, 32'hDEAD_BEEF);

        // addi x4,x0,0 reads x0. A same-cycle x0 write is also presented.
        cyc(32'h0000_0213, 1'b0, 1'b1, 5'd0, 32'h0000_5555);
        chk("x0_rs1", bus.RS1_DATA_ID, 32'd0);

        // beq x0,x0,-8.
        cyc(32'hFE00_0CE3, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("beq_imm", bus.IMM_ID, 32'hFFFF_FFF8);

        // lui x5,0x12345.
        cyc(32'h1234_52B7, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lui_imm", bus.IMM_ID,        32'h1234_5000);
        chk("lui_rd",  32'(bus.RD_ID),    32'd5);

        // Flush squashes the word at PC 24.
        cyc(32'h0010_0313, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("fl_valid", 32'(bus.VALID_ID), 32'd0);
        chk("fl_idata", bus.IDATA_ID,      32'h0000_0013);
        chk("fl_pc",    bus.PC_ID,         32'd24);

        // The all-ones word is illegal but still valid.
        cyc(32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("ill_flag",  32'(bus.ILLEGAL_ID), 32'd1);
        chk("ill_valid", 32'(bus.VALID_ID),   32'd1);
        chk("ill_pc",    bus.PC_ID,           32'd28);

        // sw x2,8(x1), with x2 written in the same cycle.
        cyc(32'h0020_A423, 1'b0, 1'b1, 5'd2, 32'h0BAD_F00D);
        chk("sw_imm", bus.IMM_ID,      32'd8);
        chk("sw_rs2", bus.RS2_DATA_ID, 32'h0BAD_F00D);

        // jal x1,-4.
        cyc(32'hFFDF_F0EF, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("jal_imm", bus.IMM_ID, 32'hFFFF_FFFC);

        // The low bits are not 2'b11, so the word is illegal.
        cyc(32'h0000_0001, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("c_ill", 32'(bus.ILLEGAL_ID), 32'd1);

        // Reset asserted between edges must clear the outputs immediately.
        bus.IDATA_IF = 32'h0000_8193;
        bus.PC_IF    = pc_ctr;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.VALID_ID), 32'd0);
        chk("ar_idata", bus.IDATA_ID,      32'h0000_0013);
        chk("ar_pc",    bus.PC_ID,         32'd0);
        chk("ar_rs1d",  bus.RS1_DATA_ID,   32'd0);
        @(negedge clk);
        rstn   = 1'b1;
        pc_ctr = 32'd0;

        cyc(32'hDEAD_0000, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("r2_e1_valid", 32'(bus.VALID_ID), 32'd0);
        // addi x3,x1,0: x1 must read as cleared.
        cyc(32'h0000_8193, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("r2_e2_valid", 32'(bus.VALID_ID), 32'd1);
        chk("r2_rs1d",     bus.RS1_DATA_ID,   32'd0);
        chk("r2_pc",       bus.PC_ID,         32'd0);

        cyc(32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'd0);
        cyc(32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
